// File: rtl/div_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the sequential divider.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the partial remainder.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] partial,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_c,
  output logic            qbit_c
);

  localparam int unsigned TW = XLEN + 1;

  logic [XLEN:0] trial;

  // Subtract as add of the inverted divisor with carry-in; bit XLEN is the borrow/sign.
  assign trial  = {1'b0, partial} + ~{1'b0, divisor} + TW'(1);
  assign qbit_c = ~trial[XLEN];
  assign rem_c  = qbit_c ? trial[XLEN-1:0] : partial;

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip straight to DONE.
module div32_seq
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t           state, state_nx;
  logic             rsel_q, rsel_nx;
  logic             qneg_q, qneg_nx;
  logic             rneg_q, rneg_nx;
  logic             spec_q, spec_nx;
  logic [XLEN-1:0]  spec_res_q, spec_res_nx;
  logic [XLEN-1:0]  quo_q, quo_nx;
  logic [XLEN-1:0]  rem_q, rem_nx;
  logic [XLEN-1:0]  dvs_q, dvs_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [XLEN-1:0]  result_nx;
  logic             busy_nx, done_nx;

  logic [XLEN-1:0]  step_partial, step_rem, quo_step, q_fix, r_fix, spec_res_c;
  logic             step_qbit, dvd_neg, dvs_neg, div_zero, sgn_ovf, special_c;

  assign step_partial = {rem_q[XLEN-2:0], quo_q[XLEN-1]};

  div_step #(.XLEN(XLEN)) u_step (
    .partial (step_partial),
    .divisor (dvs_q),
    .rem_c   (step_rem),
    .qbit_c  (step_qbit)
  );

  assign quo_step = {quo_q[XLEN-2:0], step_qbit};
  assign q_fix    = qneg_q ? -quo_step : quo_step;
  assign r_fix    = rneg_q ? -step_rem : step_rem;

  // Operand decode at acceptance: signs, special cases and their fixed result.
  assign dvd_neg    = is_signed(op) & dividend[XLEN-1];
  assign dvs_neg    = is_signed(op) & divisor[XLEN-1];
  assign div_zero   = (divisor == '0);
  assign sgn_ovf    = is_signed(op) && (dividend == MIN_NEG) && (divisor == '1);
  assign special_c  = div_zero | sgn_ovf;
  assign spec_res_c = is_rem(op) ? (div_zero ? dividend : '0)
                                 : (div_zero ? '1 : dividend);

  always_comb begin
    state_nx    = state;
    rsel_nx     = rsel_q;
    qneg_nx     = qneg_q;
    rneg_nx     = rneg_q;
    spec_nx     = spec_q;
    spec_res_nx = spec_res_q;
    quo_nx      = quo_q;
    rem_nx      = rem_q;
    dvs_nx      = dvs_q;
    cnt_nx      = cnt_q;
    result_nx   = result;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx    = S_RUN;
          rsel_nx     = is_rem(op);
          qneg_nx     = dvd_neg ^ dvs_neg;
          rneg_nx     = dvd_neg;
          spec_nx     = special_c;
          spec_res_nx = spec_res_c;
          quo_nx      = dvd_neg ? -dividend : dividend;
          dvs_nx      = dvs_neg ? -divisor : divisor;
          rem_nx      = '0;
          cnt_nx      = '0;
`ifdef DIV_FAST_SPECIAL_EN
          if (special_c) begin
            state_nx  = S_DONE;
            result_nx = spec_res_c;
          end
`endif
        end
      end
      S_RUN: begin
        quo_nx = quo_step;
        rem_nx = step_rem;
        cnt_nx = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_nx  = S_DONE;
          result_nx = spec_q ? spec_res_q : (rsel_q ? r_fix : q_fix);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rsel_q     <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      rsel_q     <= rsel_nx;
      qneg_q     <= qneg_nx;
      rneg_q     <= rneg_nx;
      spec_q     <= spec_nx;
      spec_res_q <= spec_res_nx;
      quo_q      <= quo_nx;
      rem_q      <= rem_nx;
      dvs_q      <= dvs_nx;
      cnt_q      <= cnt_nx;
      result     <= result_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed RV32M cases, random ops, back-to-back and mid-op reset.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div32_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Reference: RISC-V M-extension semantics via plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
    sa = int'(a);
    sb = int'(b);
    case (o)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sp;
    int   fast_lat;
`ifdef DIV_FAST_SPECIAL_EN
    fast_lat = 1;
`else
    fast_lat = 33;
`endif
    sp = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return sp ? fast_lat : 33;
  endfunction

  // Issue one op from a negedge; returns latency (-1 on timeout), result, busy-throughout flag,
  // the result seen in cycle 1, and leaves the bench one cycle after done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_ok,
                        output logic [31:0] res_at1);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_ok = busy;
    res_at1 = result;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      busy_ok &= busy;
    end
    if (!done) lat = -1;
    res = result;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b result=%h exp 0/0/0", busy, done, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  logic [1:0]  d_op  [12] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01,
                              2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
  logic [31:0] d_a   [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5,
                              32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0,
                              32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1};
  logic [31:0] d_exp [12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                              32'hFFFF_FFFB, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};

  task automatic test_directed();
    logic [31:0] res, r1;
    int          lat;
    logic        bok;
    for (int i = 0; i < 12; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, bok, r1);
      checks++;
      if (res !== d_exp[i]) begin
        failures++;
        $display("FAIL directed_result idx=%0d got=%h exp=%h", i, res, d_exp[i]);
      end
      checks++;
      if (lat != exp_lat(d_op[i], d_a[i], d_b[i]) || bok !== 1'b1) begin
        failures++;
        $display("FAIL directed_latency idx=%0d got=%0d busy_ok=%b exp=%0d busy_ok=1",
                 i, lat, bok, exp_lat(d_op[i], d_a[i], d_b[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, r1;
    logic [1:0]  o;
    int          lat;
    logic        bok;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'($urandom_range(0, 1)) - 32'($urandom_range(1, 9));
        4, 5:    b = b >> $urandom_range(8, 28);
        default: ;
      endcase
      run_op(o, a, b, res, lat, bok, r1);
      checks++;
      if (res !== model(o, a, b) || lat != exp_lat(o, a, b)) begin
        failures++;
        $display("FAIL random op=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                 o, a, b, res, lat, model(o, a, b), exp_lat(o, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, r_at1a, r_at1b;
    int          lat1, lat2;
    logic        bok1, bok2;
    run_op(2'b01, 32'd100, 32'd7, r1, lat1, bok1, r_at1a);
    checks++;
    if (r1 !== 32'd14 || result !== 32'd14) begin
      failures++;
      $display("FAIL b2b_first got=%h held=%h exp=%h", r1, result, 32'd14);
    end
    run_op(2'b11, 32'd1000, 32'd7, r2, lat2, bok2, r_at1b);
    checks++;
    if (r_at1b !== 32'd14) begin
      failures++;
      $display("FAIL b2b_held got=%h exp=%h", r_at1b, 32'd14);
    end
    checks++;
    if (r2 !== 32'd6 || lat2 != 33 || bok2 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got=%h lat=%0d busy_ok=%b exp=%h lat=33 busy_ok=1", r2, lat2, bok2, 32'd6);
    end
  endtask

  task automatic test_abort();
    logic        ok;
    logic [31:0] res, r1;
    int          lat;
    logic        bok;
    ok = 1'b1;
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      ok &= busy & ~done;
      start = 1'b0;
      if (cyc == 10) begin
        start = 1'b1; op = 2'b00; dividend = 32'h1234; divisor = 32'd5;
      end
      if (cyc == 20) rst_n = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy got=%b exp=1", ok);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL abort_reset busy=%b done=%b result=%h exp 0/0/0", busy, done, result);
    end
    run_op(2'b01, 32'd9, 32'd3, res, lat, bok, r1);
    checks++;
    if (res !== 32'd3 || lat != 33) begin
      failures++;
      $display("FAIL abort_after got=%h lat=%0d exp=%h lat=33", res, lat, 32'd3);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
